// File: rtl/wbs_spi_mailbox.sv
// wbs_spi_mailbox
//   Wishbone B4 pipelined slave that terminates single-beat accesses from the
//   SPI-controlled master and bridges them to two byte streams:
//     TX FIFO : bytes written by the MCU, presented first-word-fall-through
//               to local logic.
//     RX FIFO : bytes offered by local logic, read back by the MCU.
//   Register map (wb_adr_i[3:2]):
//     0 TXDATA  write pushes wb_dat_i[7:0]; reads 0
//     1 RXDATA  read pops; returns {1, 23'b0, head}, or 0 when empty
//     2 STATUS  {8'b0, rx_level, tx_level, 2'b0, rx_ovf, tx_ovf,
//                rx_empty, rx_full, tx_empty, tx_full}; write-1-clears [5:4]
//     3 CONTROL write bit0 flushes TX, bit1 flushes RX; reads 0
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wb_cyc_i .. wb_dat_i         Wishbone slave inputs
//   wb_dat_o, wb_stall_o, wb_ack_o Wishbone slave outputs
//   tx_data_o, tx_valid_o, tx_ready_i  TX byte stream (to local logic)
//   rx_data_i, rx_valid_i, rx_ready_o  RX byte stream (from local logic)
module wbs_spi_mailbox #(
  parameter int DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;

  // Bus decode
  logic       acc;
  logic [1:0] reg_sel;
  logic       wr_byte0;
  logic       tx_push_req;
  logic       stat_wr;
  logic       ctrl_wr;
  logic       tx_flush;
  logic       rx_flush;

  // FIFO state
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  lvl_t       tx_level, rx_level;
  logic       tx_ovf, rx_ovf;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;

  // Read path
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic        pend_q;
  logic [31:0] pend_dat_q;

  logic unused_bits;

  assign acc         = wb_cyc_i & wb_stb_i;
  assign reg_sel     = wb_adr_i[3:2];
  assign wr_byte0    = acc & wb_we_i & wb_sel_i[0];
  assign tx_push_req = wr_byte0 & (reg_sel == 2'd0);
  assign stat_wr     = wr_byte0 & (reg_sel == 2'd2);
  assign ctrl_wr     = wr_byte0 & (reg_sel == 2'd3);
  assign tx_flush    = ctrl_wr & wb_dat_i[0];
  assign rx_flush    = ctrl_wr & wb_dat_i[1];

  assign tx_full  = (tx_level == FULL_LEVEL);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == FULL_LEVEL);
  assign rx_empty = (rx_level == '0);

  // Full/empty are the pre-edge values, so a push into a full FIFO is
  // dropped even when a pop happens at the same edge.
  assign tx_push = tx_push_req & ~tx_full;
  assign tx_pop  = ~tx_empty & tx_ready_i;
  assign rx_push = rx_valid_i & ~rx_full;
  assign rx_pop  = acc & ~wb_we_i & (reg_sel == 2'd1) & ~rx_empty;

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_empty ? 8'h00 : tx_mem[tx_rptr];
  assign rx_ready_o = ~rx_full;
  assign wb_stall_o = 1'b0;

  assign unused_bits = ^{wb_adr_i[15:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

  // Storage arrays carry no reset; the level counters gate every use.
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wptr] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
  end

  // TX pointers and level; flush overrides any same-edge push or pop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_level <= '0;
    end else if (tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + ptr_t'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + ptr_t'(1);
      tx_level <= tx_level + lvl_t'(tx_push) - lvl_t'(tx_pop);
    end
  end

  // RX pointers and level; same structure as TX.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_level <= '0;
    end else if (rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_level <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + ptr_t'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + ptr_t'(1);
      rx_level <= rx_level + lvl_t'(rx_push) - lvl_t'(rx_pop);
    end
  end

  // Sticky overflow flags. Set is tested last so it beats a same-edge
  // write-1-to-clear; flush leaves them alone.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (stat_wr && wb_dat_i[4]) tx_ovf <= 1'b0;
      if (stat_wr && wb_dat_i[5]) rx_ovf <= 1'b0;
      if (tx_push_req && tx_full) tx_ovf <= 1'b1;
      if (rx_valid_i && rx_full)  rx_ovf <= 1'b1;
    end
  end

  assign status_word = {8'h00, 8'(rx_level), 8'(tx_level), 2'b00,
                        rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_mux = 32'h0;
    if (!wb_we_i) begin
      case (reg_sel)
        2'd1:    rd_mux = rx_empty ? 32'h0 : {1'b1, 23'h0, rx_mem[rx_rptr]};
        2'd2:    rd_mux = status_word;
        default: rd_mux = 32'h0;
      endcase
    end
  end

  // Two-stage response: read data is captured at the accepting edge (so it
  // reflects pre-edge state), and ack/data are driven one edge later. Reset
  // clears the pending stage, which drops an in-flight ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pend_q     <= 1'b0;
      pend_dat_q <= 32'h0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'h0;
    end else begin
      pend_q     <= acc;
      pend_dat_q <= acc ? rd_mux : 32'h0;
      wb_ack_o   <= pend_q;
      wb_dat_o   <= pend_q ? pend_dat_q : 32'h0;
    end
  end

endmodule
